// File: rtl/mc_delay_ctrl.sv
// Per-channel delay-line code controller: slews each channel's code one LSB at a
// time with a settle interval after every step, and can calibrate against a phase detector.
module mc_delay_ctrl #(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned DelayWidth   = 4,
  parameter int unsigned SettleCycles = 8,
  parameter int unsigned ResetCode    = 0,
  localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cfg_valid_i,
  output logic                              cfg_ready_o,
  input  logic [ChanW-1:0]                  cfg_chan_i,
  input  logic [DelayWidth-1:0]             cfg_code_i,
  input  logic                              cfg_cal_i,
  input  logic [NumChannels-1:0]            cal_sample_i,
  output logic [NumChannels*DelayWidth-1:0] delay_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              cal_found_o,
  output logic [DelayWidth-1:0]             cal_code_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] STEP   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [DelayWidth-1:0] MaxCode  = '1;
  localparam logic [DelayWidth-1:0] ResetVal = DelayWidth'(ResetCode);
  localparam logic [CntW-1:0]       CntLast  = CntW'(SettleCycles - 1);

  logic [2:0]            state, state_nx;
  logic [ChanW-1:0]      chan;
  logic                  cal_mode;
  logic [DelayWidth-1:0] target;
  logic [CntW-1:0]       cnt;
  logic [DelayWidth-1:0] codes [NumChannels];

  logic                  chan_ok;
  logic                  samp;
  logic [DelayWidth-1:0] cur;
  logic                  do_step;
  logic                  step_up;

  // Active-channel view; an out-of-range channel simply never matches.
  always_comb begin
    chan_ok = 1'b0;
    samp    = 1'b0;
    cur     = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (chan == ChanW'(c)) begin
        chan_ok = 1'b1;
        samp    = cal_sample_i[c];
        cur     = codes[c];
      end
    end
  end

  always_comb begin
    delay_o = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      delay_o[c*DelayWidth +: DelayWidth] = codes[c];
    end
  end

  assign do_step = (state == STEP) && chan_ok && (cur != target);
  assign step_up = (target > cur);

  // Direct mode returns from SETTLE to STEP, which then finishes; this keeps the
  // completion pulse one cycle after the final settle interval.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (cfg_valid_i) state_nx = STEP;
      STEP: begin
        if (!chan_ok)                        state_nx = DONE;
        else if (cur != target || cal_mode)  state_nx = SETTLE;
        else                                 state_nx = DONE;
      end
      SETTLE: begin
        if (cnt == CntLast) state_nx = (cal_mode && cur == target) ? SAMPLE : STEP;
      end
      SAMPLE: state_nx = (samp || cur == MaxCode) ? DONE : STEP;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      chan        <= '0;
      cal_mode    <= 1'b0;
      target      <= '0;
      cnt         <= '0;
      cfg_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cal_found_o <= 1'b0;
      cal_code_o  <= '0;
      for (int unsigned c = 0; c < NumChannels; c++) codes[c] <= ResetVal;
    end else begin
      state       <= state_nx;
      cfg_ready_o <= (state_nx == IDLE);
      busy_o      <= (state_nx != IDLE);
      done_o      <= (state_nx == DONE);

      if (state == IDLE && cfg_valid_i) begin
        chan     <= cfg_chan_i;
        cal_mode <= cfg_cal_i;
        target   <= cfg_cal_i ? '0 : cfg_code_i;
      end

      if (state == SETTLE && state_nx == SETTLE) cnt <= cnt + 1'b1;
      else                                       cnt <= '0;

      for (int unsigned c = 0; c < NumChannels; c++) begin
        if (do_step && chan == ChanW'(c)) begin
          if (step_up) codes[c] <= (codes[c] == MaxCode) ? codes[c] : codes[c] + 1'b1;
          else         codes[c] <= (codes[c] == '0)      ? codes[c] : codes[c] - 1'b1;
        end
      end

      if (state == SAMPLE) begin
        if (state_nx == STEP) target <= cur + 1'b1;
        if (state_nx == DONE) begin
          cal_found_o <= samp;
          if (samp) cal_code_o <= cur;
        end
      end

      if (state == STEP && !chan_ok && cal_mode) cal_found_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_delay_ctrl.sv
// Scoreboard bench for mc_delay_ctrl: default instance plus a 5-channel instance
// whose 3-bit channel field can address a nonexistent channel.
module tb_mc_delay_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [19:0] delay;
    logic        found;
    logic [3:0]  code;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;

  logic        v1 = 0, cal1 = 0, rdy1, busy1, done1, fnd1;
  logic [1:0]  ch1 = '0;
  logic [3:0]  code1 = '0, ccode1;
  logic [3:0]  samp1;
  logic [15:0] dly1;

  logic        v2 = 0, cal2 = 0, rdy2, busy2, done2, fnd2;
  logic [2:0]  ch2 = '0;
  logic [3:0]  code2 = '0, ccode2;
  logic [4:0]  samp2;
  logic [19:0] dly2;

  // Phase detector on ch2 reads 1 once its code reaches 9; ch3 never fires.
  assign samp1 = {1'b0, (dly1[11:8] >= 4'd9), 2'b00};
  assign samp2 = 5'b00001;

  mc_delay_ctrl dut1 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(v1), .cfg_ready_o(rdy1),
    .cfg_chan_i(ch1), .cfg_code_i(code1), .cfg_cal_i(cal1), .cal_sample_i(samp1),
    .delay_o(dly1), .busy_o(busy1), .done_o(done1), .cal_found_o(fnd1), .cal_code_o(ccode1)
  );

  mc_delay_ctrl #(.NumChannels(5), .DelayWidth(4), .SettleCycles(2), .ResetCode(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(v2), .cfg_ready_o(rdy2),
    .cfg_chan_i(ch2), .cfg_code_i(code2), .cfg_cal_i(cal2), .cal_sample_i(samp2),
    .delay_o(dly2), .busy_o(busy2), .done_o(done2), .cal_found_o(fnd2), .cal_code_o(ccode2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) chk("dut1_spurious_done", 32'(q1.size()), 1);
      else begin
        m1 = q1.pop_front();
        chk("dut1_done_cycle", cyc, m1.cyc);
        chk("dut1_delay", 32'(dly1), 32'(m1.delay));
        chk("dut1_cal_found", 32'(fnd1), 32'(m1.found));
        chk("dut1_cal_code", 32'(ccode1), 32'(m1.code));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) chk("dut2_spurious_done", 32'(q2.size()), 1);
      else begin
        m2 = q2.pop_front();
        chk("dut2_done_cycle", cyc, m2.cyc);
        chk("dut2_delay", 32'(dly2), 32'(m2.delay));
        chk("dut2_cal_found", 32'(fnd2), 32'(m2.found));
        chk("dut2_cal_code", 32'(ccode2), 32'(m2.code));
      end
    end
  end

  task automatic issue(input bit sel, input logic [2:0] c, input logic [3:0] code,
                       input logic cal, input int off, input logic [19:0] d,
                       input logic f, input logic [3:0] cc, output int e0);
    int n = 0;
    exp_t e;
    @(negedge clk);
    if (!sel) begin v1 = 1; ch1 = c[1:0]; code1 = code; cal1 = cal; end
    else      begin v2 = 1; ch2 = c;      code2 = code; cal2 = cal; end
    while (!(sel ? rdy2 : rdy1) && n < 400) begin @(negedge clk); n++; end
    if (!(sel ? rdy2 : rdy1)) begin
      chk("accept_timeout", n, 0);
      v1 = 0; v2 = 0; e0 = cyc;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    v1 = 0; v2 = 0;
    e0 = cyc;
    e.delay = d; e.found = f; e.code = cc; e.cyc = e0 + off;
    if (!sel) q1.push_back(e);
    else      q2.push_back(e);
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while ((sel ? q2.size() : q1.size()) != 0 && n < 400) begin @(negedge clk); n++; end
    if ((sel ? q2.size() : q1.size()) != 0) begin
      chk("done_timeout", 32'(sel ? q2.size() : q1.size()), 0);
      if (sel) q2.delete(); else q1.delete();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_delay1"}, 32'(dly1), 0);
    chk({tag, "_delay2"}, 32'(dly2), 0);
    chk({tag, "_ready"}, 32'(rdy1), 1);
    chk({tag, "_busy"}, 32'(busy1), 0);
    chk({tag, "_done"}, 32'(done1), 0);
    chk({tag, "_found"}, 32'(fnd1), 0);
    chk({tag, "_code"}, 32'(ccode1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int n;
    // Reset asserted before the first clock edge exercises the asynchronous path.
    #1 rst = 1;
    #1 chk_reset("por");
    @(negedge clk); @(negedge clk);
    rst = 0;

    issue(0, 3'd1, 4'd5, 0, 46, 20'h00050, 0, 4'd0, e0);
    for (int k = 0; k < 5; k++) begin
      while (cyc < e0 + 1 + 9 * k) @(negedge clk);
      chk("ramp_up_code", 32'(dly1[7:4]), k + 1);
      chk("ramp_up_others", 32'(dly1 & 16'hFF0F), 0);
      chk("ramp_up_ready", 32'(rdy1), 0);
    end
    drain(0);

    issue(0, 3'd1, 4'd5, 0, 1, 20'h00050, 0, 4'd0, e0);
    drain(0);
    issue(0, 3'd0, 4'd3, 0, 28, 20'h00053, 0, 4'd0, e0);
    drain(0);
    issue(0, 3'd0, 4'd1, 0, 19, 20'h00051, 0, 4'd0, e0);
    for (int k = 0; k < 2; k++) begin
      while (cyc < e0 + 1 + 9 * k) @(negedge clk);
      chk("ramp_down_code", 32'(dly1[3:0]), 2 - k);
    end
    drain(0);

    issue(0, 3'd2, 4'd3, 0, 28, 20'h00351, 0, 4'd0, e0);
    drain(0);
    issue(0, 3'd2, 4'd0, 1, 118, 20'h00951, 1, 4'd9, e0);
    drain(0);
    issue(0, 3'd3, 4'd0, 1, 160, 20'h0F951, 0, 4'd9, e0);
    drain(0);

    @(negedge clk);
    #3 rst = 1;
    #1 chk_reset("rst2");
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Abort a ramp mid-flight while a second request waits.
    issue(0, 3'd0, 4'd12, 0, 109, 20'h0000C, 0, 4'd0, e0);
    v1 = 1; ch1 = 2'd2; code1 = 4'd2; cal1 = 0;
    n = 0;
    while (dly1[3:0] != 4'd4 && n < 200) begin @(negedge clk); n++; end
    chk("abort_reached_4", 32'(dly1[3:0]), 4);
    #3 rst = 1;
    #1 chk_reset("abort");
    q1.delete();
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    v1 = 0;
    chk("held_busy", 32'(busy1), 1);
    chk("held_ready", 32'(rdy1), 0);
    begin
      exp_t e;
      e.delay = 20'h00200; e.found = 0; e.code = 4'd0; e.cyc = e0 + 19;
      q1.push_back(e);
    end
    drain(0);

    issue(1, 3'd0, 4'd0, 1, 4, 20'h00000, 1, 4'd0, e0);
    drain(1);
    issue(1, 3'd4, 4'd3, 0, 10, 20'h30000, 1, 4'd0, e0);
    drain(1);
    issue(1, 3'd5, 4'd0, 1, 1, 20'h30000, 0, 4'd0, e0);
    drain(1);
    issue(1, 3'd5, 4'd7, 0, 1, 20'h30000, 0, 4'd0, e0);
    drain(1);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_delay_ctrl.md
# mc_delay_ctrl

Multi-channel controller for the tapped mux-tree clock delay lines (`delay_line_*` macros). It owns one registered delay code per channel and applies a requested code by stepping one LSB at a time, with a settle interval after each step, so the downstream mux tree never takes a large code jump. It also has a calibration mode: per channel, it sweeps the code upward from 0 and records the first code at which an external phase-detector sample reads 1.

## Interface
- `NumChannels`, default 4: number of delay lines controlled, ≥1.
- `DelayWidth`, default 4: delay code width per channel (max code = 2^DelayWidth−1).
- `SettleCycles`, default 8: cycles waited after every code step, ≥1.
- `ResetCode`, default 0: code loaded into every channel on reset.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset is asynchronous and active-high.
- `cfg_valid_i` in 1: request valid.
- `cfg_ready_o` out 1: request accept; transfer on `cfg_valid_i && cfg_ready_o`.
- `cfg_chan_i` in max(1,$clog2(NumChannels)): target channel.
- `cfg_code_i` in DelayWidth: target code (direct mode only).
- `cfg_cal_i` in 1: 1 = calibration sweep, 0 = direct set.
- `cal_sample_i` in NumChannels: per-channel phase-detector sample, already synchronised to `clk_i`.
- `delay_o` out NumChannels*DelayWidth: channel c code on bits [c*DelayWidth +: DelayWidth].
- `busy_o` out 1: request in progress.
- `done_o` out 1: one-cycle completion pulse.
- `cal_found_o` out 1: last calibration hit; held until the next completion.
- `cal_code_o` out DelayWidth: code at the last calibration hit; held.

## Operation
- FSM states: IDLE, STEP, SETTLE, SAMPLE, DONE.
- In IDLE, `cfg_ready_o`=1. All other states drive it to 0. Requests are never dropped; the requester holds `cfg_valid_i`.
- On accept, latch the channel, mode and target.
  - Direct mode: target = `cfg_code_i`.
  - Calibration mode: phase 1 target = 0.
- STEP: move the active channel code one LSB toward the target (+1 or −1), then go to SETTLE.
- SETTLE: count SettleCycles cycles. Then:
  - code == target, direct mode → DONE.
  - code == target, calibration phase 1 → SAMPLE.
  - code != target → STEP.
- Accept with code already equal to target:
  - Direct mode → DONE immediately.
  - Calibration mode → SETTLE once, then SAMPLE.
- SAMPLE (calibration, phase 2):
  - `cal_sample_i[chan]`=1 → `cal_found_o`←1, `cal_code_o`←code, DONE.
  - Else if code = max → `cal_found_o`←0, code left at max, DONE.
  - Else STEP (+1), SETTLE, SAMPLE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- Direct-mode completion leaves `cal_found_o`/`cal_code_o` unchanged.
- Only the active channel's code ever changes. Other channels hold.
- `cfg_chan_i` ≥ NumChannels: accepted, no code change, DONE next cycle. In calibration mode `cal_found_o`←0.
- Code arithmetic saturates within [0, 2^DelayWidth−1] and never wraps. Step direction comes from an unsigned compare.
- `busy_o`=1 in every state except IDLE.

## Timing
- Reset values:
  - `delay_o` = ResetCode on all channels.
  - `cfg_ready_o`=1, `busy_o`=0, `done_o`=0, `cal_found_o`=0, `cal_code_o`=0.
  - FSM = IDLE.
- Reset asserted mid-operation aborts immediately: codes return to ResetCode and no `done_o` is issued.
- Let E0 be the accept edge and S = SettleCycles.
  - Step k (k = 0..D−1, D = |target − code|) updates `delay_o` at edge E0+1+k(S+1).
  - Direct with D>0: `done_o` is high for the cycle after edge E0+D(S+1)+1.
  - Direct with D=0: `done_o` is high for the cycle after edge E0+1.
- Calibration: each swept code is sampled exactly S cycles after it appears on `delay_o`. The sample is taken in the SAMPLE cycle, one cycle after SETTLE ends.
- `busy_o` rises at E0+1 and falls at the edge where `done_o` falls.
- `delay_o`, `busy_o`, `done_o`, `cal_*` and `cfg_ready_o` are all registered outputs; no combinational input-to-output path.

## Test plan
Defaults: NumChannels=4, DelayWidth=4, SettleCycles=8.
- Reset: assert `rst_i` asynchronously → `delay_o`=16'h0000, `cfg_ready_o`=1, `busy_o`=0, `done_o`=0, `cal_found_o`=0, `cal_code_o`=0, independent of `clk_i`.
- Direct set, ch1 0→5: bits [7:4] step 1,2,3,4,5 at E0+1, +10, +19, +28, +37. `done_o` pulses once after edge E0+46. Channels 0, 2, 3 stay 0. `cfg_ready_o`=0 throughout.
- Direct set, ch1 5→5: `done_o` after edge E0+1, `delay_o` unchanged. Then ch0 from 3 to 1 → codes 2, 1 (down-ramp).
- Calibration, ch2 starting at code 3, `cal_sample_i[2]`=1 iff code ≥ 9: ramp 2, 1, 0; sweep 1..9 → `cal_found_o`=1, `cal_code_o`=9, ch2 code 9, single `done_o`.
- Calibration, ch3 with `cal_sample_i[3]`=0 constant: sweep to 15 → `cal_found_o`=0, ch3 code 15. Also, `cfg_chan_i`=5 (invalid, 3-bit) → no code change, `done_o` after edge E0+1.
- Reset during ch0 ramp 0→12 while ch0 code = 4 and `cfg_valid_i` held for a second request → all codes 0, `busy_o`=0, no `done_o`. The held request is accepted on the first edge after reset deasserts.
